// File: rtl/ahb5_pkg.sv
// Purpose : shared AHB5 encodings and helpers used by the SRAM subordinate
//           and the transaction generator.
// Contents: htrans_t, transfer-size and response constants, the subordinate
//           FSM state type, byte-lane and alignment helpers.
package ahb5_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] SZ_BYTE = 3'd0;
   localparam logic [2:0] SZ_HALF = 3'd1;
   localparam logic [2:0] SZ_WORD = 3'd2;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR1 = 2'b10,
      ST_ERR2 = 2'b11
   } sram_state_t;

   // Little-endian lane enables for a transfer of the given size.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_BYTE: be = 4'b0001 << addr_lo;
         SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = |addr_lo;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ahb5_wait_lfsr.sv
// Purpose : 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that supplies the
//           pseudo-random wait-state count; advances one step per enable.
// Ports   : i_clk, i_rst_n (async active-low, reloads SEED),
//           i_step (advance one step), o_state (current LFSR value).
module ahb5_wait_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_step,
   output logic [15:0] o_state
);

   // Right-shifting Galois form: feedback mask for taps 16,14,13,11.
   localparam logic [15:0] TAP_MASK = 16'hB400;

   logic [15:0] r_lfsr;
   logic [15:0] w_lfsr_nxt;

   assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAP_MASK : 16'h0000);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= SEED;
      end else if (i_step) begin
         r_lfsr <= w_lfsr_nxt;
      end
   end

   assign o_state = r_lfsr;

endmodule

// File: rtl/ahb5_sram_subordinate.sv
// Purpose : AHB5 subordinate with a word-organised SRAM behind it.
//           Inserts pseudo-random wait states and answers illegal transfers
//           with the two-cycle ERROR response. Burst beats are treated as
//           independent transfers.
// Ports   : HCLK, HRESETn (async active-low); address phase HSEL, HADDR,
//           HTRANS, HWRITE, HSIZE, HBURST/HPROT (ignored); data phase HWDATA;
//           HREADY (bus ready in); HREADYOUT, HRESP, HRDATA (out).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; completes a pending zero/post-wait data phase, accepts
// ST_WAIT | data phase stalled, r_cnt more stall cycles after this one
// ST_ERR1 | first ERROR cycle (HREADYOUT=0, HRESP=1)
// ST_ERR2 | second ERROR cycle (HREADYOUT=1, HRESP=1), may accept
module ahb5_sram_subordinate
   import ahb5_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [7:0]  WAIT_MASK = 8'd3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   sram_state_t       r_state, w_state_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt;
   logic              r_dp_valid, w_dp_valid_nxt;
   logic [ADDR_W-1:0] r_word;
   logic              r_write;
   logic [3:0]        r_be;
   logic [31:0]       r_mem [0:(2**ADDR_W)-1];

   logic [15:0]       w_lfsr;
   logic [7:0]        w_wait;
   logic              w_in_region;
   logic              w_err;
   logic              w_accept;
   logic              w_complete;
   logic              w_unused;

   assign w_unused = ^{HBURST, HPROT, HTRANS[0], w_lfsr[15:8]};

   ahb5_wait_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .i_clk   (HCLK),
      .i_rst_n (HRESETn),
      .i_step  (w_accept),
      .o_state (w_lfsr)
   );

   assign w_wait      = w_lfsr[7:0] & WAIT_MASK;
   assign w_in_region = (HADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign w_err       = (HSIZE > SZ_WORD) | misaligned(HSIZE, HADDR[1:0]) | !w_in_region;

   // Only ST_IDLE and ST_ERR2 drive HREADYOUT high, so an address phase can
   // only be taken there; the guard also protects against a bus that muxes
   // HREADY from elsewhere while this block is stalling.
   assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_ERR2)) &&
                       HSEL && HREADY && HTRANS[1];

   // A post-wait data phase returns to ST_IDLE with r_dp_valid still set,
   // so the completing cycle is always an IDLE cycle.
   assign w_complete = (r_state == ST_IDLE) && r_dp_valid;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_dp_valid_nxt = r_dp_valid;
      case (r_state)
         ST_IDLE, ST_ERR2: begin
            w_state_nxt    = ST_IDLE;
            w_dp_valid_nxt = 1'b0;
            if (w_accept) begin
               if (w_err) begin
                  w_state_nxt = ST_ERR1;
               end else begin
                  w_dp_valid_nxt = 1'b1;
                  if (w_wait != 8'd0) begin
                     w_state_nxt = ST_WAIT;
                     w_cnt_nxt   = w_wait - 8'd1;
                  end
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         ST_ERR1: w_state_nxt = ST_ERR2;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = RESP_OKAY;
      case (r_state)
         ST_WAIT: HREADYOUT = 1'b0;
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = RESP_ERROR;
         end
         ST_ERR2: HRESP = RESP_ERROR;
         default: ;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 8'd0;
         r_dp_valid <= 1'b0;
         r_word     <= '0;
         r_write    <= 1'b0;
         r_be       <= 4'b0000;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_dp_valid <= w_dp_valid_nxt;
         if (w_accept) begin
            r_word  <= HADDR[ADDR_W+1:2];
            r_write <= HWRITE;
            r_be    <= byte_lanes(HSIZE, HADDR[1:0]);
         end
      end
   end

   // Array is deliberately not reset; reset clears r_dp_valid, which is
   // what discards a write caught mid data phase.
   always_ff @(posedge HCLK) begin
      if (w_complete && r_write) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
               r_mem[r_word][8*i +: 8] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   assign HRDATA = (w_complete && !r_write) ? r_mem[r_word] : 32'h0000_0000;

endmodule

// File: tb/tb_ahb5_sram_subordinate.sv
// Directed bench for ahb5_sram_subordinate. Two instances share the bus:
// u_dut_a is zero-wait (WAIT_MASK=0), u_dut_b uses WAIT_MASK=3 with seed
// 16'h0003, giving wait counts 3, 1, 0, ... after each reset.
module tb_ahb5_sram_subordinate;
   import ahb5_pkg::*;

   logic        hclk;
   logic        hresetn;
   logic        hsel_a, hsel_b;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout_a, hreadyout_b;
   logic        hresp_a, hresp_b;
   logic [31:0] hrdata_a, hrdata_b;

   int n_tests = 0;
   int n_fail  = 0;
   int lowcnt;

   // An unselected, idle subordinate always holds HREADYOUT high, so the
   // AND is equivalent to muxing the active one.
   assign hready = hreadyout_a & hreadyout_b;

   ahb5_sram_subordinate #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_MASK(8'd0), .LFSR_SEED(16'hACE1)) u_dut_a (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
      .HREADY(hready), .HREADYOUT(hreadyout_a), .HRESP(hresp_a), .HRDATA(hrdata_a)
   );

   ahb5_sram_subordinate #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_MASK(8'd3), .LFSR_SEED(16'h0003)) u_dut_b (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
      .HREADY(hready), .HREADYOUT(hreadyout_b), .HRESP(hresp_b), .HRDATA(hrdata_b)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic ap(input logic sa, input logic sb, input logic [31:0] a, input logic w, input logic [2:0] sz);
      hsel_a = sa;
      hsel_b = sb;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      htrans = NONSEQ;
   endtask

   task automatic ap_idle();
      hsel_a = 1'b0;
      hsel_b = 1'b0;
      haddr  = 32'h0;
      hwrite = 1'b0;
      hsize  = SZ_WORD;
      htrans = IDLE;
   endtask

   task automatic nxt();
      @(negedge hclk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hresetn = 1'b0;
      hburst  = 3'b000;
      hprot   = 4'b0011;
      hwdata  = 32'h0;
      ap_idle();
      nxt(); nxt();
      hresetn = 1'b1;
      nxt();

      check("rst_ready_a", 32'(hreadyout_a), 32'd1);
      check("rst_resp_a",  32'(hresp_a),     32'd0);
      check("rst_rdata_a", hrdata_a,         32'h0);
      check("rst_ready_b", 32'(hreadyout_b), 32'd1);

      // Zero-wait pipelined stream on instance A.
      ap(1, 0, 32'h00, 1, SZ_WORD);
      nxt();
      hwdata = 32'h0BAD_F00D; ap(1, 0, 32'h10, 1, SZ_WORD);
      nxt();
      hwdata = 32'hDEAD_BEEF; ap(1, 0, 32'h10, 0, SZ_WORD);
      check("zw_ready_wr", 32'(hreadyout_a), 32'd1);
      nxt();
      check("zw_rdata",    hrdata_a,         32'hDEAD_BEEF);
      check("zw_ready_rd", 32'(hreadyout_a), 32'd1);
      ap(1, 0, 32'h12, 1, SZ_HALF);
      nxt();
      check("rdata_wr_phase", hrdata_a, 32'h0);
      hwdata = 32'hCAFE_1234; ap(1, 0, 32'h10, 0, SZ_WORD);
      nxt();
      check("half_merge", hrdata_a, 32'hCAFE_BEEF);
      ap(1, 0, 32'h20, 1, SZ_WORD);
      nxt();
      hwdata = 32'h1122_3344; ap(1, 0, 32'h22, 1, SZ_BYTE);
      nxt();
      hwdata = 32'h55AA_6677; ap(1, 0, 32'h20, 0, SZ_WORD);
      nxt();
      check("byte_merge", hrdata_a, 32'h11AA_3344);
      ap_idle();
      nxt();
      check("rdata_idle", hrdata_a, 32'h0);

      // Misaligned word read, then an OKAY read straight out of ERR2.
      ap(1, 0, 32'h02, 0, SZ_WORD);
      nxt();
      check("mis_err1_ready", 32'(hreadyout_a), 32'd0);
      check("mis_err1_resp",  32'(hresp_a),     32'd1);
      ap_idle();
      nxt();
      check("mis_err2_ready", 32'(hreadyout_a), 32'd1);
      check("mis_err2_resp",  32'(hresp_a),     32'd1);
      ap(1, 0, 32'h10, 0, SZ_WORD);
      nxt();
      check("after_err_resp",  32'(hresp_a), 32'd0);
      check("after_err_rdata", hrdata_a,     32'hCAFE_BEEF);

      // Out-of-region write, then an oversize read back to back.
      ap(1, 0, 32'h0000_1000, 1, SZ_WORD);
      nxt();
      check("oor_err1_ready", 32'(hreadyout_a), 32'd0);
      check("oor_err1_resp",  32'(hresp_a),     32'd1);
      hwdata = 32'hFFFF_FFFF; ap_idle();
      nxt();
      check("oor_err2_ready", 32'(hreadyout_a), 32'd1);
      check("oor_err2_resp",  32'(hresp_a),     32'd1);
      ap(1, 0, 32'h00, 0, 3'd3);
      nxt();
      check("sz3_err1_ready", 32'(hreadyout_a), 32'd0);
      check("sz3_err1_resp",  32'(hresp_a),     32'd1);
      ap_idle();
      nxt();
      check("sz3_err2_ready", 32'(hreadyout_a), 32'd1);
      check("sz3_err2_resp",  32'(hresp_a),     32'd1);
      ap(1, 0, 32'h00, 0, SZ_WORD);
      nxt();
      check("no_err_write", hrdata_a, 32'h0BAD_F00D);
      ap_idle();
      nxt();

      // Wait states on instance B: W=3 for the write, W=1 for the held read.
      ap(0, 1, 32'h30, 1, SZ_WORD);
      nxt();
      check("wait_resp", 32'(hresp_b), 32'd0);
      hwdata = 32'h1234_5678; ap(0, 1, 32'h30, 0, SZ_WORD);
      lowcnt = 0;
      while (hreadyout_b == 1'b0 && lowcnt < 10) begin
         lowcnt++;
         nxt();
      end
      check("wait3_low_cycles", 32'(lowcnt), 32'd3);
      nxt();
      check("wait1_ready", 32'(hreadyout_b), 32'd0);
      check("wait1_rdata", hrdata_b,         32'h0);
      ap_idle();
      nxt();
      check("wait1_done",  32'(hreadyout_b), 32'd1);
      check("wait_rdata",  hrdata_b,         32'h1234_5678);

      // Clean reset reloads the seed so the next write sees W=3 again.
      hresetn = 1'b0;
      nxt();
      hresetn = 1'b1;
      nxt();
      ap(0, 1, 32'h30, 1, SZ_WORD);
      nxt();
      check("mid_wait_ready", 32'(hreadyout_b), 32'd0);
      hwdata = 32'h5555_AAAA; ap_idle();
      #2 hresetn = 1'b0;
      #1;
      check("mid_rst_ready", 32'(hreadyout_b), 32'd1);
      check("mid_rst_resp",  32'(hresp_b),     32'd0);
      check("mid_rst_rdata", hrdata_b,         32'h0);
      nxt();
      hresetn = 1'b1;
      ap(0, 1, 32'h30, 0, SZ_WORD);
      nxt();
      ap_idle();
      lowcnt = 0;
      while (hreadyout_b == 1'b0 && lowcnt < 10) begin
         lowcnt++;
         nxt();
      end
      check("reseed_low_cycles", 32'(lowcnt), 32'd3);
      check("write_discarded",   hrdata_b,    32'h1234_5678);
      nxt();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
